// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its source queues.
package wb_pkg;

  localparam int NREG   = 15;
  localparam int DEST_W = 4;
  localparam int DATA_W = 32;
  localparam int SEQ_W  = 3;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
    logic [SEQ_W-1:0]  seq;
  } wb_entry_t;

  // True when stamp x was issued before stamp y. Stamps wrap, so age is the
  // modular distance; with at most four entries in flight the distance from
  // an older to a younger stamp is always 1..3 (upper half means "younger").
  function automatic logic seq_older(input logic [SEQ_W-1:0] x,
                                     input logic [SEQ_W-1:0] y);
    logic [SEQ_W-1:0] d;
    d = y - x;
    return (d != '0) && !d[SEQ_W-1];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback queue: DEPTH entries, occupancy-count full/empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CAP  = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  wb_entry_t     mem [DEPTH];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage, written on push only.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CAP);
  assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Two-source register-file writeback arbiter with age-ordered WAW handling
// and a per-register pending-write scoreboard for decode hazard checks.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = wb_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DEST_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DEST_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  input  logic [DEST_W-1:0] src1,
  input  logic [DEST_W-1:0] src2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              writeBackEn,
  output logic [DEST_W-1:0] Dest_wb,
  output logic [DATA_W-1:0] Result_WB,
  output logic              bad_dest
);

  localparam logic [DEST_W:0] NREG_X = (DEST_W + 1)'(NREG);

  logic [SEQ_W-1:0] seq;
  logic             prio_a;
  logic             acc_a, acc_b;
  logic             a_full, a_empty, b_full, b_empty;
  logic             pop_a, pop_b, pop_v, rr_flip;
  wb_entry_t        a_in, b_in, a_head, b_head, pop_e;
  logic [2:0]       pending   [NREG];
  logic [2:0]       pend_next [NREG];

  function automatic logic in_range(input logic [DEST_W-1:0] d);
    return {1'b0, d} < NREG_X;
  endfunction

  assign a_ready = !rst && !a_full;
  assign b_ready = !rst && !b_full;
  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;

  // A is stamped first when both sources are accepted together.
  assign a_in = '{dest: a_dest, data: a_data, seq: seq};
  assign b_in = '{dest: b_dest, data: b_data, seq: seq + SEQ_W'(acc_a)};

  assign bad_dest = (acc_a && !in_range(a_dest)) || (acc_b && !in_range(b_dest));

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (acc_a),
    .din   (a_in),
    .pop   (pop_a),
    .head  (a_head),
    .full  (a_full),
    .empty (a_empty)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (acc_b),
    .din   (b_in),
    .pop   (pop_b),
    .head  (b_head),
    .full  (b_full),
    .empty (b_empty)
  );

  // Head selection: lone head wins; same dest goes by age; otherwise round-robin.
  always_comb begin
    pop_a   = 1'b0;
    pop_b   = 1'b0;
    rr_flip = 1'b0;
    if (!rst) begin
      if (!a_empty && !b_empty) begin
        if (a_head.dest == b_head.dest) begin
          pop_a = seq_older(a_head.seq, b_head.seq);
        end else begin
          pop_a   = prio_a;
          rr_flip = 1'b1;
        end
        pop_b = !pop_a;
      end else begin
        pop_a = !a_empty;
        pop_b = !b_empty;
      end
    end
  end

  assign pop_v = pop_a || pop_b;
  assign pop_e = pop_a ? a_head : b_head;

  // Scoreboard next state: accepts add, the pop subtracts, same-cycle cancels.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_next[r] = pending[r]
                   + 3'(acc_a && (a_dest == DEST_W'(r)))
                   + 3'(acc_b && (b_dest == DEST_W'(r)))
                   - 3'(pop_v && (pop_e.dest == DEST_W'(r)));
    end
  end

  // Scoreboard, sequence stamp and round-robin priority state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) pending[r] <= '0;
      seq    <= '0;
      prio_a <= 1'b1;
    end else begin
      pending <= pend_next;
      seq     <= seq + SEQ_W'(acc_a) + SEQ_W'(acc_b);
      if (rr_flip) prio_a <= !prio_a;
    end
  end

  // Registered write port; out-of-range entries drain without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeBackEn <= 1'b0;
      Dest_wb     <= '0;
      Result_WB   <= '0;
    end else begin
      writeBackEn <= pop_v && in_range(pop_e.dest);
      if (pop_v && in_range(pop_e.dest)) begin
        Dest_wb   <= pop_e.dest;
        Result_WB <= pop_e.data;
      end
    end
  end

  // Hazard: an outstanding queued write, or the write currently on the port.
  always_comb begin
    hazard1 = writeBackEn && (Dest_wb == src1);
    hazard2 = writeBackEn && (Dest_wb == src2);
    if (in_range(src1) && (pending[src1] != '0)) hazard1 = 1'b1;
    if (in_range(src2) && (pending[src2] != '0)) hazard2 = 1'b1;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_dest, b_dest, src1, src2;
  logic [31:0] a_data, b_data;
  logic        hazard1, hazard2, writeBackEn, bad_dest;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [35:0] wlog[$];

  wb_arbiter #(.DEPTH(2), .NREG(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_dest      (a_dest),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_dest      (b_dest),
    .b_data      (b_data),
    .src1        (src1),
    .src2        (src2),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .writeBackEn (writeBackEn),
    .Dest_wb     (Dest_wb),
    .Result_WB   (Result_WB),
    .bad_dest    (bad_dest)
  );

  always #5 clk = ~clk;

  // Record every register-file write, sampled mid-cycle.
  always @(negedge clk) begin
    if (writeBackEn === 1'b1) wlog.push_back({Dest_wb, Result_WB});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0;
    a_dest = '0; b_dest = '0; a_data = '0; b_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    wlog.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); src1 = 4'd0; src2 = 4'd0;
    tick(); tick();
    total_cnt++;
    if ({a_ready, b_ready, writeBackEn, bad_dest} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b required 0000", {a_ready, b_ready, writeBackEn, bad_dest});
    else pass_cnt++;
    total_cnt++;
    if (Dest_wb !== 4'd0) $display("FAIL reset_dest: got %0d required 0", Dest_wb);
    else pass_cnt++;
    total_cnt++;
    if (Result_WB !== 32'd0) $display("FAIL reset_result: got %h required 0", Result_WB);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({a_ready, b_ready} !== 2'b11)
      $display("FAIL reset_ready_after: got %b required 11", {a_ready, b_ready});
    else pass_cnt++;
  endtask

  task automatic test_single_write();
    do_reset();
    src1 = 4'd3;
    a_valid = 1'b1; a_dest = 4'd3; a_data = 32'hDEAD_BEEF;
    tick();
    a_valid = 1'b0;
    #1;
    total_cnt++;
    if ({hazard1, writeBackEn} !== 2'b10)
      $display("FAIL single_c1: hazard1/wben got %b required 10", {hazard1, writeBackEn});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({writeBackEn, hazard1, Dest_wb, Result_WB} !== {1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF})
      $display("FAIL single_c2: got wben=%b hz=%b dest=%0d data=%h required 1 1 3 deadbeef",
               writeBackEn, hazard1, Dest_wb, Result_WB);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({writeBackEn, hazard1, Dest_wb} !== {1'b0, 1'b0, 4'd3})
      $display("FAIL single_c3: got wben=%b hz=%b dest=%0d required 0 0 3",
               writeBackEn, hazard1, Dest_wb);
    else pass_cnt++;
  endtask

  task automatic test_alternate();
    int na, nb, ia, ib;
    logic toggle_ok, alt_ok, order_ok;
    do_reset();
    na = 0; nb = 0; toggle_ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      a_valid = 1'b1; a_dest = 4'd1; a_data = 32'(100 + na);
      b_valid = 1'b1; b_dest = 4'd2; b_data = 32'(200 + nb);
      #1;
      if (c == 2) begin
        total_cnt++;
        if ({a_ready, b_ready} !== 2'b10)
          $display("FAIL alt_ready_c2: got %b required 10", {a_ready, b_ready});
        else pass_cnt++;
      end
      if (c == 3) begin
        total_cnt++;
        if ({a_ready, b_ready} !== 2'b01)
          $display("FAIL alt_ready_c3: got %b required 01", {a_ready, b_ready});
        else pass_cnt++;
      end
      if (c >= 2 && a_ready === b_ready) toggle_ok = 1'b0;
      if (a_ready) na++;
      if (b_ready) nb++;
      tick();
    end
    idle();
    repeat (8) tick();
    total_cnt++;
    if (toggle_ok !== 1'b1) $display("FAIL alt_ready_toggle: got 0 required 1");
    else pass_cnt++;
    total_cnt++;
    if (wlog.size() != na + nb || na != 7 || nb != 7)
      $display("FAIL alt_count: got writes=%0d na=%0d nb=%0d required 14 7 7", wlog.size(), na, nb);
    else pass_cnt++;
    alt_ok = 1'b1; order_ok = 1'b1; ia = 0; ib = 0;
    for (int k = 0; k < wlog.size(); k++) begin
      if (k < 8 && wlog[k][35:32] !== ((k % 2 == 0) ? 4'd1 : 4'd2)) alt_ok = 1'b0;
      if (wlog[k][35:32] === 4'd1) begin
        if (wlog[k][31:0] !== 32'(100 + ia)) order_ok = 1'b0;
        ia++;
      end else if (wlog[k][35:32] === 4'd2) begin
        if (wlog[k][31:0] !== 32'(200 + ib)) order_ok = 1'b0;
        ib++;
      end else order_ok = 1'b0;
    end
    total_cnt++;
    if (alt_ok !== 1'b1) $display("FAIL alt_grant_order: got non-alternating grants required A,B,A,B");
    else pass_cnt++;
    total_cnt++;
    if (order_ok !== 1'b1) $display("FAIL alt_data_order: got lost/duplicated entry required in-order data");
    else pass_cnt++;
  endtask

  task automatic test_waw();
    do_reset();
    b_valid = 1'b1; b_dest = 4'd5; b_data = 32'h11;
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_dest = 4'd5; a_data = 32'h22;
    tick();
    idle();
    repeat (4) tick();
    a_valid = 1'b1; a_dest = 4'd5; a_data = 32'h33;
    b_valid = 1'b1; b_dest = 4'd5; b_data = 32'h44;
    tick();
    idle();
    repeat (5) tick();
    total_cnt++;
    if (wlog.size() != 4) $display("FAIL waw_count: got %0d required 4", wlog.size());
    else pass_cnt++;
    total_cnt++;
    if (wlog.size() < 2 || wlog[0] !== {4'd5, 32'h11} || wlog[1] !== {4'd5, 32'h22})
      $display("FAIL waw_b_then_a: got first writes out of order required 11 then 22");
    else pass_cnt++;
    total_cnt++;
    if (wlog.size() < 4 || wlog[2] !== {4'd5, 32'h33} || wlog[3] !== {4'd5, 32'h44})
      $display("FAIL waw_same_cycle: got later writes out of order required 33 then 44");
    else pass_cnt++;
  endtask

  task automatic test_seq_wrap();
    int k;
    logic ok;
    do_reset();
    k = 0;
    for (int c = 0; c < 60 && k < 20; c++) begin
      if (a_ready && k < 20) begin
        a_valid = 1'b1; a_dest = 4'd7; a_data = 32'(k); k++;
      end else a_valid = 1'b0;
      if (b_ready && k < 20) begin
        b_valid = 1'b1; b_dest = 4'd7; b_data = 32'(k); k++;
      end else b_valid = 1'b0;
      tick();
    end
    idle();
    repeat (8) tick();
    total_cnt++;
    if (wlog.size() != 20) $display("FAIL wrap_count: got %0d required 20", wlog.size());
    else pass_cnt++;
    ok = 1'b1;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] !== {4'd7, 32'(i)}) ok = 1'b0;
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL wrap_order: got out-of-order writes required data 0..19 in order");
    else pass_cnt++;
  endtask

  task automatic test_bad_dest();
    do_reset();
    a_valid = 1'b1; a_dest = 4'd15; a_data = 32'h55;
    #1;
    total_cnt++;
    if (bad_dest !== 1'b1) $display("FAIL bad_pulse_a: got %b required 1", bad_dest);
    else pass_cnt++;
    tick();
    a_valid = 1'b0;
    #1;
    total_cnt++;
    if (bad_dest !== 1'b0) $display("FAIL bad_pulse_end: got %b required 0", bad_dest);
    else pass_cnt++;
    b_valid = 1'b1; b_dest = 4'd15; b_data = 32'h56;
    #1;
    total_cnt++;
    if (bad_dest !== 1'b1) $display("FAIL bad_pulse_b: got %b required 1", bad_dest);
    else pass_cnt++;
    tick();
    idle();
    repeat (4) tick();
    total_cnt++;
    if (wlog.size() != 0) $display("FAIL bad_no_write: got %0d writes required 0", wlog.size());
    else pass_cnt++;
    a_valid = 1'b1; a_dest = 4'd4; a_data = 32'h66;
    tick();
    idle();
    repeat (4) tick();
    total_cnt++;
    if (wlog.size() != 1 || wlog[0] !== {4'd4, 32'h66})
      $display("FAIL bad_drained: got %0d writes required single write 4/66", wlog.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_flush();
    do_reset();
    a_valid = 1'b1; a_dest = 4'd1; a_data = 32'hA1;
    b_valid = 1'b1; b_dest = 4'd3; b_data = 32'hB3;
    tick();
    a_dest = 4'd2; a_data = 32'hA2;
    b_dest = 4'd6; b_data = 32'hB6;
    tick();
    idle();
    total_cnt++;
    if ({writeBackEn, Dest_wb, Result_WB} !== {1'b1, 4'd1, 32'hA1})
      $display("FAIL flush_pre: got wben=%b dest=%0d data=%h required 1 1 a1",
               writeBackEn, Dest_wb, Result_WB);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({writeBackEn, Dest_wb, Result_WB, a_ready, b_ready} !== 39'd0)
      $display("FAIL flush_zero: got wben=%b dest=%0d data=%h rdy=%b%b required all 0",
               writeBackEn, Dest_wb, Result_WB, a_ready, b_ready);
    else pass_cnt++;
    rst = 1'b0;
    wlog.delete();
    src1 = 4'd3;
    #1;
    total_cnt++;
    if (hazard1 !== 1'b0) $display("FAIL flush_hazard: got %b required 0", hazard1);
    else pass_cnt++;
    repeat (6) tick();
    total_cnt++;
    if (wlog.size() != 0) $display("FAIL flush_no_write: got %0d writes required 0", wlog.size());
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    src1 = '0; src2 = '0;
    idle();
    test_reset();
    test_single_write();
    test_alternate();
    test_waw();
    test_seq_wrap();
    test_bad_dest();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
